// File: rtl/id_bypass_stage_pkg.sv
// rtl/id_bypass_stage_pkg.sv - shared constants, field helpers and exception codes for the decode bypass stage
//
// Purpose: single home for the decode-stage constants used by the stage,
// its bypass muxes and downstream consumers.
// Contents:
//   EXC_W / EXC_FLAG_BIT  exception code width and the "exception present" bit
//   RS_*/RT_* + rs_of/rt_of  source-register field slices of a MIPS word
//   NOP_INSTR             word stored in place of a faulting instruction
//   EXC_SELF_JUMP / EXC_RESERVED_INSTR  codes raised further down the pipe
package id_bypass_stage_pkg;

    localparam int EXC_W        = 6;
    localparam int EXC_FLAG_BIT = EXC_W - 1;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [EXC_W-1:0] EXC_SELF_JUMP      = 6'b100000;
    localparam logic [EXC_W-1:0] EXC_RESERVED_INSTR = 6'b101010;

    function automatic logic [4:0] rs_of(input logic [31:0] instr);
        return instr[RS_HI:RS_LO];
    endfunction

    function automatic logic [4:0] rt_of(input logic [31:0] instr);
        return instr[RT_HI:RT_LO];
    endfunction

endpackage

// File: rtl/id_bypass_stage_if.sv
// rtl/id_bypass_stage_if.sv - fetch/regfile/bypass/execute bundle around the decode bypass stage
//
// Purpose: groups every non-clock, non-reset signal of id_bypass_stage.
// Modports:
//   master  the surrounding pipeline (fetch, regfile, producers, execute)
//   slave   the decode stage itself
// Signals:
//   in_valid/in_ready/in_pc/in_instr/in_exc/in_delay_slot  fetch-side handshake
//   flush                                                  kill held entry
//   rf_raddr1/2, rf_rdata1/2                               regfile read port
//   fwd_valid/fwd_dst/fwd_pending/fwd_data                 bypass sources (0 = youngest)
//   out_valid/out_ready/out_pc/out_instr/out_val1/out_val2/out_exc/out_delay_slot
//                                                          execute-side handshake
//   hazard_stall, stall_cnt                                interlock status
interface id_bypass_stage_if #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int NUM_FWD = 3,
    parameter int EXC_W   = 6,
    parameter int CNT_W   = 16
);

    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_W-1:0]          in_pc;
    logic [31:0]                in_instr;
    logic [EXC_W-1:0]           in_exc;
    logic                       in_delay_slot;

    logic                       flush;

    logic [REG_W-1:0]           rf_raddr1;
    logic [REG_W-1:0]           rf_raddr2;
    logic [DATA_W-1:0]          rf_rdata1;
    logic [DATA_W-1:0]          rf_rdata2;

    logic [NUM_FWD-1:0]         fwd_valid;
    logic [NUM_FWD*REG_W-1:0]   fwd_dst;
    logic [NUM_FWD-1:0]         fwd_pending;
    logic [NUM_FWD*DATA_W-1:0]  fwd_data;

    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          out_pc;
    logic [31:0]                out_instr;
    logic [DATA_W-1:0]          out_val1;
    logic [DATA_W-1:0]          out_val2;
    logic [EXC_W-1:0]           out_exc;
    logic                       out_delay_slot;

    logic                       hazard_stall;
    logic [CNT_W-1:0]           stall_cnt;

    modport master (
        output in_valid, in_pc, in_instr, in_exc, in_delay_slot,
        output flush,
        output rf_rdata1, rf_rdata2,
        output fwd_valid, fwd_dst, fwd_pending, fwd_data,
        output out_ready,
        input  in_ready,
        input  rf_raddr1, rf_raddr2,
        input  out_valid, out_pc, out_instr, out_val1, out_val2, out_exc, out_delay_slot,
        input  hazard_stall, stall_cnt
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_exc, in_delay_slot,
        input  flush,
        input  rf_rdata1, rf_rdata2,
        input  fwd_valid, fwd_dst, fwd_pending, fwd_data,
        input  out_ready,
        output in_ready,
        output rf_raddr1, rf_raddr2,
        output out_valid, out_pc, out_instr, out_val1, out_val2, out_exc, out_delay_slot,
        output hazard_stall, stall_cnt
    );

endinterface

// File: rtl/id_bypass_stage_bypass_mux.sv
// rtl/id_bypass_stage_bypass_mux.sv - priority operand bypass for one source register
//
// Purpose: resolves one operand from the regfile or the youngest matching
// producer, and reports whether that value is actually available yet.
// Ports:
//   idx          in  REG_W           register index being read
//   rf_data      in  DATA_W          regfile read data for idx
//   fwd_valid    in  NUM_FWD         producer i writes a register
//   fwd_dst      in  NUM_FWD*REG_W   producer i destination index
//   fwd_pending  in  NUM_FWD         producer i result not produced yet
//   fwd_data     in  NUM_FWD*DATA_W  producer i result
//   value        out DATA_W          resolved operand
//   ready        out 1               operand usable this cycle
module bypass_mux #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int NUM_FWD = 3
) (
    input  logic [REG_W-1:0]          idx,
    input  logic [DATA_W-1:0]         rf_data,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD*REG_W-1:0]  fwd_dst,
    input  logic [NUM_FWD-1:0]        fwd_pending,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0]         value,
    output logic                      ready
);

    always_comb begin
        value = rf_data;
        ready = 1'b1;
        // Walk oldest to youngest so the youngest (lowest index) match is the
        // last assignment and therefore wins.
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_dst[i*REG_W +: REG_W] == idx)) begin
                value = fwd_data[i*DATA_W +: DATA_W];
                ready = !fwd_pending[i];
            end
        end
        // $0 is hard-wired; a producer "writing" it must never be bypassed or
        // cause an interlock.
        if (idx == '0) begin
            value = '0;
            ready = 1'b1;
        end
    end

endmodule

// File: rtl/id_bypass_stage.sv
// rtl/id_bypass_stage.sv - decode pipeline register with elastic handshake, operand bypass and load-use interlock
//
// Purpose: holds one decoded instruction between fetch and execute, resolves
// its rs/rt operands every cycle and withholds issue while a matching
// producer is still pending.
// Ports:
//   clk     in  1   rising-edge clock
//   resetn  in  1   asynchronous active-low reset
//   bus     slave modport of id_bypass_stage_if (fetch, regfile, bypass
//           sources, execute handshake, hazard status)
module id_bypass_stage
    import id_bypass_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int NUM_FWD = 3,
    parameter int EXC_W   = id_bypass_stage_pkg::EXC_W,
    parameter int CNT_W   = 16
) (
    input  logic          clk,
    input  logic          resetn,
    id_bypass_stage_if.slave bus
);

    logic                held_valid;
    logic [DATA_W-1:0]   pc_q;
    logic [31:0]         instr_q;
    logic [EXC_W-1:0]    exc_q;
    logic                delay_slot_q;
    logic [CNT_W-1:0]    stall_cnt_q;

    logic [REG_W-1:0]    rs_idx;
    logic [REG_W-1:0]    rt_idx;
    logic [DATA_W-1:0]   val1;
    logic [DATA_W-1:0]   val2;
    logic                rdy1;
    logic                rdy2;

    logic                exc_flag;
    logic                hazard;
    logic                issue;
    logic                accept;
    logic                capture;

    assign rs_idx = REG_W'(rs_of(instr_q));
    assign rt_idx = REG_W'(rt_of(instr_q));

    bypass_mux #(
        .DATA_W  (DATA_W),
        .REG_W   (REG_W),
        .NUM_FWD (NUM_FWD)
    ) u_mux_rs (
        .idx         (rs_idx),
        .rf_data     (bus.rf_rdata1),
        .fwd_valid   (bus.fwd_valid),
        .fwd_dst     (bus.fwd_dst),
        .fwd_pending (bus.fwd_pending),
        .fwd_data    (bus.fwd_data),
        .value       (val1),
        .ready       (rdy1)
    );

    bypass_mux #(
        .DATA_W  (DATA_W),
        .REG_W   (REG_W),
        .NUM_FWD (NUM_FWD)
    ) u_mux_rt (
        .idx         (rt_idx),
        .rf_data     (bus.rf_rdata2),
        .fwd_valid   (bus.fwd_valid),
        .fwd_dst     (bus.fwd_dst),
        .fwd_pending (bus.fwd_pending),
        .fwd_data    (bus.fwd_data),
        .value       (val2),
        .ready       (rdy2)
    );

    // A faulting entry carries no real operands, so it must drain without
    // waiting on producers.
    assign exc_flag = exc_q[EXC_W-1];
    assign hazard   = held_valid && !exc_flag && !(rdy1 && rdy2);
    assign issue    = held_valid && !hazard;

    // Refill on the same edge the held entry leaves, giving full throughput.
    assign accept   = !held_valid || (issue && bus.out_ready);
    assign capture  = bus.in_valid && accept && !bus.flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            held_valid   <= 1'b0;
            pc_q         <= '0;
            instr_q      <= '0;
            exc_q        <= '0;
            delay_slot_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            if (bus.flush) begin
                held_valid <= 1'b0;
            end else if (capture) begin
                held_valid   <= 1'b1;
                pc_q         <= bus.in_pc;
                // Fetch faults never reach execute as real opcodes; the NOP
                // also keeps the dead word from naming source registers.
                instr_q      <= bus.in_exc[EXC_W-1] ? NOP_INSTR : bus.in_instr;
                exc_q        <= bus.in_exc;
                delay_slot_q <= bus.in_delay_slot;
            end else if (issue && bus.out_ready) begin
                held_valid <= 1'b0;
            end

            // Performance counter survives flushes; only reset clears it.
            if (hazard && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign bus.in_ready       = accept;
    assign bus.rf_raddr1      = rs_idx;
    assign bus.rf_raddr2      = rt_idx;
    assign bus.out_valid      = issue;
    assign bus.out_pc         = pc_q;
    assign bus.out_instr      = instr_q;
    assign bus.out_val1       = val1;
    assign bus.out_val2       = val2;
    assign bus.out_exc        = exc_q;
    assign bus.out_delay_slot = delay_slot_q;
    assign bus.hazard_stall   = hazard;
    assign bus.stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_id_bypass_stage.sv
// tb/tb_id_bypass_stage.sv - directed self-checking bench for id_bypass_stage
module tb_id_bypass_stage;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int NUM_FWD = 3;
    localparam int EXC_W   = 6;
    localparam int CNT_W   = 8;

    localparam logic [31:0] I_ADDIU_2_0_5 = 32'h2402_0005; // addiu $2,$0,5
    localparam logic [31:0] I_ADDU_5_3_4  = 32'h0064_2821; // addu  $5,$3,$4
    localparam logic [31:0] I_ADDIU_6_4_1 = 32'h2486_0001; // addiu $6,$4,1

    logic clk;
    logic resetn;
    int   tests;
    int   fails;

    id_bypass_stage_if #(
        .DATA_W(DATA_W), .REG_W(REG_W), .NUM_FWD(NUM_FWD), .EXC_W(EXC_W), .CNT_W(CNT_W)
    ) bus ();

    id_bypass_stage #(
        .DATA_W(DATA_W), .REG_W(REG_W), .NUM_FWD(NUM_FWD), .EXC_W(EXC_W), .CNT_W(CNT_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed off-edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        resetn            = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_pc         = '0;
        bus.in_instr      = '0;
        bus.in_exc        = '0;
        bus.in_delay_slot = 1'b0;
        bus.flush         = 1'b0;
        bus.rf_rdata1     = '0;
        bus.rf_rdata2     = '0;
        bus.fwd_valid     = '0;
        bus.fwd_dst       = '0;
        bus.fwd_pending   = '0;
        bus.fwd_data      = '0;
        bus.out_ready     = 1'b0;

        // Reset state
        tick();
        tick();
        settle();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_hazard", 32'(bus.hazard_stall), 32'd0);
        check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        check("rst_out_pc", bus.out_pc, 32'd0);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_out_exc", 32'(bus.out_exc), 32'd0);
        check("rst_out_ds", 32'(bus.out_delay_slot), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // First instruction right out of reset, one-cycle latency
        resetn        = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'hBFC0_0000;
        bus.in_instr  = I_ADDIU_2_0_5;
        bus.rf_rdata1 = 32'hDEAD_BEEF;
        bus.rf_rdata2 = 32'h0000_0077;
        tick();
        bus.in_valid = 1'b0;
        settle();
        check("t1_out_valid", 32'(bus.out_valid), 32'd1);
        check("t1_out_pc", bus.out_pc, 32'hBFC0_0000);
        check("t1_out_instr", bus.out_instr, I_ADDIU_2_0_5);
        check("t1_raddr1", 32'(bus.rf_raddr1), 32'd0);
        check("t1_raddr2", 32'(bus.rf_raddr2), 32'd2);
        check("t1_val1_zero_reg", bus.out_val1, 32'd0);
        check("t1_val2_rf", bus.out_val2, 32'h77);
        check("t1_in_ready_blocked", 32'(bus.in_ready), 32'd0);

        // Consume and capture on the same edge; forwarding priority
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'hBFC0_0004;
        bus.in_instr  = I_ADDU_5_3_4;
        settle();
        check("t2_in_ready_passthru", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.rf_rdata1   = 32'h11;
        bus.rf_rdata2   = 32'h44;
        bus.fwd_valid   = 3'b101;
        bus.fwd_dst     = {5'd3, 5'd0, 5'd3};
        bus.fwd_data    = {32'h33, 32'h0, 32'h22};
        settle();
        check("t2_out_pc", bus.out_pc, 32'hBFC0_0004);
        check("t2_val1_fwd0_prio", bus.out_val1, 32'h22);
        check("t2_val2_rf", bus.out_val2, 32'h44);
        bus.fwd_valid = 3'b100;
        settle();
        check("t2_val1_fwd2", bus.out_val1, 32'h33);
        bus.fwd_valid = 3'b000;
        settle();
        check("t2_val1_rf", bus.out_val1, 32'h11);

        // Load-use interlock for two cycles, released combinationally
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h0000_0008;
        bus.in_instr  = I_ADDIU_6_4_1;
        tick();
        bus.in_pc       = 32'h0000_000C;
        bus.fwd_valid   = 3'b001;
        bus.fwd_dst     = {5'd0, 5'd0, 5'd4};
        bus.fwd_data    = {32'h0, 32'h0, 32'h55};
        bus.fwd_pending = 3'b001;
        settle();
        check("t3_c1_hazard", 32'(bus.hazard_stall), 32'd1);
        check("t3_c1_out_valid", 32'(bus.out_valid), 32'd0);
        check("t3_c1_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        settle();
        check("t3_c2_hazard", 32'(bus.hazard_stall), 32'd1);
        check("t3_c2_out_pc", bus.out_pc, 32'h8);
        check("t3_c2_cnt", 32'(bus.stall_cnt), 32'd1);
        tick();
        bus.fwd_pending = 3'b000;
        settle();
        check("t3_c3_cnt", 32'(bus.stall_cnt), 32'd2);
        check("t3_c3_out_valid", 32'(bus.out_valid), 32'd1);
        check("t3_c3_hazard", 32'(bus.hazard_stall), 32'd0);
        check("t3_c3_val1", bus.out_val1, 32'h55);
        check("t3_c3_in_ready", 32'(bus.in_ready), 32'd1);

        // Flush of a stalled entry beats a simultaneous offer
        tick();
        bus.fwd_pending = 3'b001;
        bus.in_pc       = 32'h0000_0010;
        bus.flush       = 1'b1;
        settle();
        check("t4_pre_out_pc", bus.out_pc, 32'hC);
        check("t4_pre_hazard", 32'(bus.hazard_stall), 32'd1);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        settle();
        check("t4_out_valid", 32'(bus.out_valid), 32'd0);
        check("t4_hazard", 32'(bus.hazard_stall), 32'd0);
        check("t4_in_ready", 32'(bus.in_ready), 32'd1);
        check("t4_not_captured", bus.out_pc, 32'hC);
        check("t4_cnt_kept", 32'(bus.stall_cnt), 32'd3);

        // Exception-flagged entry ignores pending producer
        bus.out_ready     = 1'b0;
        bus.in_valid      = 1'b1;
        bus.in_pc         = 32'h0000_0014;
        bus.in_instr      = I_ADDIU_6_4_1;
        bus.in_exc        = 6'b100100;
        bus.in_delay_slot = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        settle();
        check("t5_out_valid", 32'(bus.out_valid), 32'd1);
        check("t5_out_instr_nop", bus.out_instr, 32'd0);
        check("t5_out_exc", 32'(bus.out_exc), 32'h24);
        check("t5_hazard", 32'(bus.hazard_stall), 32'd0);
        check("t5_out_ds", 32'(bus.out_delay_slot), 32'd1);
        check("t5_cnt", 32'(bus.stall_cnt), 32'd3);
        bus.out_ready = 1'b1;
        tick();
        settle();
        check("t5_drained", 32'(bus.out_valid), 32'd0);

        // Continuous hazard for 2^CNT_W+3 cycles saturates the counter
        bus.in_valid      = 1'b1;
        bus.in_pc         = 32'h0000_0018;
        bus.in_exc        = '0;
        bus.in_delay_slot = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < (1 << CNT_W) + 3; i++) tick();
        settle();
        check("t6_sat", 32'(bus.stall_cnt), 32'hFF);
        check("t6_still_stalled", 32'(bus.hazard_stall), 32'd1);

        // Asynchronous reset mid-stall
        #1;
        resetn = 1'b0;
        #1;
        check("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("t6_rst_hazard", 32'(bus.hazard_stall), 32'd0);
        check("t6_rst_cnt", 32'(bus.stall_cnt), 32'd0);
        check("t6_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back stream, one issue per cycle
        tick();
        resetn          = 1'b1;
        bus.fwd_valid   = '0;
        bus.fwd_pending = '0;
        bus.out_ready   = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_instr    = I_ADDU_5_3_4;
        bus.in_pc       = 32'h100;
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.in_pc = 32'h100 + 32'(4 * (k + 1));
            settle();
            check("t7_out_valid", 32'(bus.out_valid), 32'd1);
            check("t7_out_pc", bus.out_pc, 32'h100 + 32'(4 * k));
            check("t7_in_ready", 32'(bus.in_ready), 32'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        settle();
        check("t7_idle", 32'(bus.out_valid), 32'd0);
        check("t7_cnt_zero", 32'(bus.stall_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
